// File: rtl/backoff_engine.sv
// backoff_engine: slave side of the backoff handshake. Acks a held request
// after 2^exp cycles, doubling the wait per completed backoff up to MAX_EXP.
// Optional feature macro: BACKOFF_JITTER_EN (adds LFSR jitter of up to
// 2^exp-1 extra cycles to each wait).
module backoff_engine #(
  parameter int unsigned MIN_EXP   = 0,
  parameter int unsigned MAX_EXP   = 10,
  parameter int unsigned STAT_W    = 32,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              bo_valid_i,
  input  logic              bo_interrupt_i,
  output logic              bo_ack_o,
  input  logic              clear_i,
  output logic              busy_o,
  output logic [3:0]        exp_o,
  output logic [STAT_W-1:0] stat_o
);

  localparam int unsigned CW = MAX_EXP + 2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_e;

  // Reject configurations that cannot work at elaboration time.
  if (LFSR_SEED == 16'h0 || MAX_EXP > 15 || MIN_EXP > MAX_EXP) begin : g_bad_cfg
    $error("backoff_engine: illegal parameter set");
  end

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [3:0]        exp_q, exp_d;
  logic [STAT_W-1:0] stat_q, stat_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;
  logic [CW-1:0]     wait_m1;
  logic [CW-1:0]     load_val;

`ifdef BACKOFF_JITTER_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR, taps 16,14,13,11; free-running every cycle.
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // Counter load: base wait plus jitter masked to the same number of bits.
  always_comb begin
    wait_m1  = (CW'(1) << exp_q) - CW'(1);
    load_val = wait_m1 + (CW'(lfsr_q) & wait_m1);
  end
`else
  // Counter load: exact base wait.
  always_comb begin
    wait_m1  = (CW'(1) << exp_q) - CW'(1);
    load_val = wait_m1;
  end
`endif

  // Next-state logic for FSM, wait counter, exponent and statistic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    stat_d  = stat_q;
    unique case (state_q)
      S_IDLE: begin
        if (bo_valid_i && bo_interrupt_i) begin
          state_d = S_ACK;
        end else if (bo_valid_i) begin
          state_d = S_WAIT;
          cnt_d   = load_val;
        end
      end
      S_WAIT: begin
        if (!bo_valid_i) begin
          state_d = S_IDLE;
        end else if (bo_interrupt_i) begin
          state_d = S_ACK;
        end else if (cnt_q == '0) begin
          state_d = S_ACK;
          if (exp_q < 4'(MAX_EXP)) exp_d = exp_q + 4'd1;
          if (stat_q != '1) stat_d = stat_q + STAT_W'(1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Clear overrides any same-cycle completion increment.
    if (clear_i) exp_d = 4'(MIN_EXP);
    ack_d  = (state_d == S_ACK);
    busy_d = (state_d != S_IDLE);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      exp_q   <= 4'(MIN_EXP);
      stat_q  <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      stat_q  <= stat_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

`ifdef BACKOFF_JITTER_EN
  // Jitter LFSR register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr_q <= LFSR_SEED;
    else         lfsr_q <= lfsr_d;
  end
`endif

  assign bo_ack_o = ack_q;
  assign busy_o   = busy_q;
  assign exp_o    = exp_q;
  assign stat_o   = stat_q;

endmodule

// File: tb/tb_backoff_engine.sv
// Directed bench for backoff_engine (MIN_EXP=0, MAX_EXP=4, STAT_W=3).
module tb_backoff_engine;

  localparam int unsigned STAT_W = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              valid;
  logic              intr;
  logic              clear;
  logic              ack;
  logic              busy;
  logic [3:0]        expo;
  logic [STAT_W-1:0] stat;

  int nvec = 0;
  int nerr = 0;

  backoff_engine #(
    .MIN_EXP  (0),
    .MAX_EXP  (4),
    .STAT_W   (STAT_W),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .bo_valid_i    (valid),
    .bo_interrupt_i(intr),
    .bo_ack_o      (ack),
    .clear_i       (clear),
    .busy_o        (busy),
    .exp_o         (expo),
    .stat_o        (stat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    nvec++;
    assert (got === want) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Raise valid from IDLE; return number of edges until ack (-1 on timeout).
  task automatic do_req(input int clr_at, input int int_at, output int n);
    n = -1;
    valid = 1'b1;
    for (int i = 1; i <= 80; i++) begin
      clear = (i == clr_at);
      intr  = (i == int_at);
      tick;
      clear = 1'b0;
      intr  = 1'b0;
      if (ack === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic req(input string tag, input int clr_at, input int int_at,
                     input int want_n, input int want_e, input int want_s);
    int n;
    do_req(clr_at, int_at, n);
    check({tag, " latency"}, n, want_n);
    check({tag, " busy@ack"}, 32'(busy), 32'd1);
    check({tag, " exp"}, 32'(expo), want_e);
    check({tag, " stat"}, 32'(stat), want_s);
    valid = 1'b0;
    tick;
    check({tag, " ack one-cycle"}, 32'(ack), 32'd0);
    check({tag, " idle busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int any_ack;
    rst_n = 1'b0;
    valid = 1'b0;
    intr  = 1'b0;
    clear = 1'b0;
    #2;
    check("rst ack", 32'(ack), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst exp", 32'(expo), 32'd0);
    check("rst stat", 32'(stat), 32'd0);
    tick;
    tick;
    rst_n = 1'b1;
    tick;

`ifdef BACKOFF_JITTER_EN
    begin
      int n, w, e, lo, hi, minw, maxw;
      minw = 1000;
      maxw = 0;
      for (int i = 0; i < 1004; i++) begin
        e  = (i < 4) ? i : 4;
        lo = 1 << e;
        hi = (2 << e) - 1;
        do_req(0, 0, n);
        w = n - 1;
        check("jitter range", 32'(w >= lo && w <= hi), 32'd1);
        if (i >= 4) begin
          if (w < minw) minw = w;
          if (w > maxw) maxw = w;
        end
        valid = 1'b0;
        tick;
      end
      check("jitter spread", 32'(maxw > minw), 32'd1);
    end
`else
    // Exponent growth and saturation at MAX_EXP=4: waits 1,2,4,8,16,16.
    req("grow0", 0, 0, 2, 1, 1);
    req("grow1", 0, 0, 3, 2, 2);
    req("grow2", 0, 0, 5, 3, 3);
    req("grow3", 0, 0, 9, 4, 4);
    req("grow4", 0, 0, 17, 4, 5);
    req("grow5", 0, 0, 17, 4, 6);
    // Interrupt in cycle t+5 of a WAIT: ack at t+6, exp/stat unchanged.
    req("intr wait", 0, 6, 6, 4, 6);
    // Valid and interrupt together in IDLE: ack next cycle.
    req("intr idle", 0, 1, 1, 4, 6);
    // Interrupt alone in IDLE is ignored.
    intr = 1'b1;
    tick;
    intr = 1'b0;
    check("lone intr busy", 32'(busy), 32'd0);
    check("lone intr ack", 32'(ack), 32'd0);
    // Clear during WAIT: 16-cycle wait kept, exp restarts from 0 then +1.
    req("clr wait", 4, 0, 17, 1, 7);
    // Statistic saturates at 7.
    req("stat sat", 0, 0, 3, 2, 7);
    // Clear in the expiry cycle at exp=2 wins over the increment.
    req("clr collide", 5, 0, 5, 0, 7);
    req("refill0", 0, 0, 2, 1, 7);
    req("refill1", 0, 0, 3, 2, 7);
    // Withdraw mid-WAIT at exp=2.
    valid = 1'b1;
    tick;
    check("wd busy", 32'(busy), 32'd1);
    tick;
    valid = 1'b0;
    any_ack = 0;
    tick;
    check("wd idle busy", 32'(busy), 32'd0);
    check("wd exp", 32'(expo), 32'd2);
    for (int i = 0; i < 6; i++) begin
      if (ack === 1'b1) any_ack = 1;
      tick;
    end
    check("wd no ack", 32'(any_ack), 32'd0);
    // Asynchronous reset mid-WAIT.
    valid = 1'b1;
    tick;
    tick;
    #1 rst_n = 1'b0;
    #1;
    check("arst ack", 32'(ack), 32'd0);
    check("arst busy", 32'(busy), 32'd0);
    check("arst exp", 32'(expo), 32'd0);
    check("arst stat", 32'(stat), 32'd0);
    valid = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
    check("post rst ack", 32'(ack), 32'd0);
    // Basic wait after reset.
    req("basic", 0, 0, 2, 1, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
